// File: rtl/mprj_io_cfg_serializer.sv
// mprj_io_cfg_serializer: shifts per-pad GPIO config words into the control-block daisy chain,
// then strobes serial_load so every pad applies its new configuration at once.
module mprj_io_cfg_serializer #(
    parameter int IO_PADS  = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       xfer,
    output logic [$clog2(IO_PADS)-1:0] cfg_idx,
    input  logic [CFG_BITS-1:0]        cfg_word,
    output logic                       serial_clock,
    output logic                       serial_data_out,
    output logic                       serial_load,
    output logic                       busy,
    output logic                       done
);
    localparam int PW = $clog2(IO_PADS);
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD_LO, LOAD_HI, DONE} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       pad_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DW-1:0]       div;
    logic [CFG_BITS-1:0] shreg;
    logic                timed, phase_end, shifting;

    assign timed     = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LOAD_LO) || (state == LOAD_HI);
    assign phase_end = timed && (div == DW'(CLK_DIV - 1));
    assign shifting  = (state == SHIFT_LO) || (state == SHIFT_HI);

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = xfer ? FETCH : IDLE;
            FETCH:    state_nx = SHIFT_LO;
            SHIFT_LO: state_nx = phase_end ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: state_nx = !phase_end ? SHIFT_HI :
                                 (bit_cnt != '0) ? SHIFT_LO :
                                 (pad_cnt != '0) ? FETCH : LOAD_LO;
            LOAD_LO:  state_nx = phase_end ? LOAD_HI : LOAD_LO;
            LOAD_HI:  state_nx = phase_end ? DONE : LOAD_HI;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // One divider times every phase; it restarts at each phase boundary.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pad_cnt <= '0;
            bit_cnt <= '0;
            div     <= '0;
            shreg   <= '0;
        end else begin
            div <= (timed && !phase_end) ? div + 1'b1 : '0;
            if (state == IDLE && xfer) pad_cnt <= PW'(IO_PADS - 1);
            if (state == FETCH) begin
                shreg   <= cfg_word;
                bit_cnt <= BW'(CFG_BITS - 1);
            end
            if (state == SHIFT_HI && phase_end) begin
                shreg <= shreg << 1;
                if (bit_cnt != '0)      bit_cnt <= bit_cnt - 1'b1;
                else if (pad_cnt != '0) pad_cnt <= pad_cnt - 1'b1;
            end
        end
    end

    assign cfg_idx         = pad_cnt;
    assign serial_clock    = (state == SHIFT_HI);
    assign serial_data_out = shifting && shreg[CFG_BITS-1];
    assign serial_load     = (state == LOAD_HI);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
endmodule
